mul_div_unit: RTL and testbench

//   Iterative multiply/divide unit with architectural HI/LO registers, placed beside the ALU in the execute stage.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mul_div_unit.sv | 160 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   MDU_WIDTH    default operand width (HI/LO are each this wide)
//   mdu_op_e     operation encoding as driven on the op port
//   mdu_state_e  sequencer states: IDLE -> RUN -> FINISH -> IDLE
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring shift-subtract) over
// WIDTH iterations on a single shared accumulator, then applies the sign fix
// and writes {hi,lo}. Divide by zero completes immediately with a flag.
//   clock        rising-edge clock
//   reset        synchronous, active-high; aborts any op without writeback
//   start/op     launch request and operation, sampled only while idle
//   A, B         multiplicand/dividend and multiplier/divisor
//   mthi/mtlo    write wdata into HI/LO while idle and not starting
//   busy         operation in progress
//   done         one-cycle pulse when hi/lo carry a new result
//   div_by_zero  set with done for a DIV/DIVU with B==0; held until next done
//   hi, lo       architectural HI/LO registers
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int AW = 2 * WIDTH + 1;

  mdu_state_e       state;
  logic [AW-1:0]    acc;       // mul: {carry, partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0] opnd;      // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [WIDTH-1:0] count;
  logic             is_div_q;
  logic             neg_q;     // negate product / quotient
  logic             neg_r;     // negate remainder

  // Operand decode for the start-sampling edge.
  mdu_op_e          op_e;
  logic             op_div, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // NOTE: every always_comb output gets a value on every path (here by plain
  // straight-line assignment, below by a default first) so no latch is inferred.
  always_comb begin
    op_e      = mdu_op_e'(op);
    op_div    = (op_e == MDU_DIV) || (op_e == MDU_DIVU);
    op_signed = (op_e == MDU_MULT) || (op_e == MDU_DIV);
    a_neg     = op_signed & A[WIDTH-1];
    b_neg     = op_signed & B[WIDTH-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
  end

  // One iteration step of either algorithm, sharing the accumulator.
  logic [WIDTH:0]  mul_sum, div_diff;
  logic [AW-1:0]   div_shift, acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    div_shift = acc << 1;
    // Bit WIDTH of the difference is the borrow: set when the shifted
    // remainder is smaller than the divisor.
    div_diff  = div_shift[AW-1:WIDTH] - {1'b0, opnd};
    acc_step  = acc >> 1;
    if (is_div_q) begin
      acc_step = div_shift;
      if (!div_diff[WIDTH]) begin
        acc_step[AW-1:WIDTH] = div_diff;
        acc_step[0]          = 1'b1;
      end
    end else if (acc[0]) begin
      acc_step = {mul_sum, acc[WIDTH-1:0]} >> 1;
    end
  end

  // Sign fix applied on the FINISH edge.
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;

  always_comb begin
    prod_raw = acc[2*WIDTH-1:0];
    quo_raw  = acc[WIDTH-1:0];
    rem_raw  = acc[2*WIDTH-1:WIDTH];
    prod_fix = neg_q ? -prod_raw : prod_raw;
    quo_fix  = neg_q ? -quo_raw : quo_raw;
    rem_fix  = neg_r ? -rem_raw : rem_raw;
  end

  // NOTE: the datapath registers carry no reset; they are always loaded on
  // the start edge before anything reads them, so reset would only add fan-out.
  always_ff @(posedge clock) begin
    if (state == S_IDLE && start) begin
      acc      <= op_div ? {{(WIDTH+1){1'b0}}, a_mag} : {{(WIDTH+1){1'b0}}, b_mag};
      opnd     <= op_div ? b_mag : a_mag;
      count    <= '0;
      is_div_q <= op_div;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
    end else if (state == S_RUN) begin
      acc   <= acc_step;
      count <= count + WIDTH'(1);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op_div && B == '0) begin
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        S_RUN: begin
          if (count == WIDTH'(WIDTH - 1)) state <= S_FINISH;
        end
        S_FINISH: begin
          if (is_div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done        <= 1'b1;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases followed by
// randomized operations, compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'd0;
  logic [31:0] A     = '0;
  logic [31:0] B     = '0;
  logic        mthi  = 1'b0;
  logic        mtlo  = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  // Reference architectural state.
  logic [31:0] exp_hi  = '0;
  logic [31:0] exp_lo  = '0;
  logic        exp_dbz = 1'b0;

  mul_div_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: full-width integer arithmetic on the operation's rules.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic dz, output logic [31:0] mh, output logic [31:0] ml);
    longint      sa, sb, ua, ub;
    logic [63:0] p, q, r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    dz = 1'b0;
    mh = exp_hi;
    ml = exp_lo;
    case (o)
      2'd0: begin p = 64'(sa * sb); {mh, ml} = p; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; {mh, ml} = p; end
      2'd2: if (b == 0) dz = 1'b1;
            else begin q = 64'(sa / sb); r = 64'(sa % sb); ml = q[31:0]; mh = r[31:0]; end
      default: if (b == 0) dz = 1'b1;
            else begin q = 64'(ua / ub); r = 64'(ua % ub); ml = q[31:0]; mh = r[31:0]; end
    endcase
  endtask

  // Launch one op in the current cycle and return in its done cycle.
  // With disturb set, the cycle after launch also drives start/mthi/mtlo,
  // all of which must be ignored while busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input string tag);
    logic        dz;
    logic [31:0] mh, ml;
    int          cycles;
    model(o, a, b, dz, mh, ml);
    start = 1'b1; op = o; A = a; B = b;
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'($urandom_range(3)); A = $urandom; B = $urandom;
    if (dz) begin
      check({tag, " dz done"}, 64'(done), 64'(1));
      check({tag, " dz flag"}, 64'(div_by_zero), 64'(1));
      check({tag, " dz busy"}, 64'(busy), 64'(0));
      check({tag, " dz hilo"}, {hi, lo}, {exp_hi, exp_lo});
      exp_dbz = 1'b1;
      return;
    end
    check({tag, " busy"}, 64'(busy), 64'(1));
    cycles = 0;
    if (disturb) begin
      start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
      tick();
      cycles = 1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      check({tag, " busy-mt hilo"}, {hi, lo}, {exp_hi, exp_lo});
    end
    while (done !== 1'b1 && cycles < 100) begin
      if (busy !== 1'b1) check({tag, " busy drop"}, 64'(busy), 64'(1));
      tick();
      cycles++;
    end
    exp_hi = mh; exp_lo = ml; exp_dbz = 1'b0;
    check({tag, " latency"}, 64'(cycles), 64'(33));
    check({tag, " done busy"}, 64'(busy), 64'(0));
    check({tag, " hilo"}, {hi, lo}, {exp_hi, exp_lo});
    check({tag, " flag"}, 64'(div_by_zero), 64'(0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle done", 64'(done), 64'(0));
      check("idle busy", 64'(busy), 64'(0));
    end
  endtask

  logic [31:0] corner [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5};

  initial begin
    bit seen_done;
    logic [31:0] ra, rb;

    // Reset
    tick(); tick();
    reset = 1'b0;
    check("rst hi", 64'(hi), 64'(0));
    check("rst lo", 64'(lo), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst done", 64'(done), 64'(0));
    check("rst flag", 64'(div_by_zero), 64'(0));

    // Directed arithmetic
    run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult -2*3");
    check("mult -2*3 hi const", 64'(hi), 64'hFFFF_FFFF);
    check("mult -2*3 lo const", 64'(lo), 64'hFFFF_FFFA);
    idle(1);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu max");
    check("multu hi const", 64'(hi), 64'hFFFF_FFFE);
    check("multu lo const", 64'(lo), 64'h1);
    idle(1);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div -7/2");
    check("div -7/2 lo const", 64'(lo), 64'hFFFF_FFFD);
    check("div -7/2 hi const", 64'(hi), 64'hFFFF_FFFF);
    run_op(2'd3, 32'd7, 32'd2, 1'b0, "divu 7/2 b2b");
    check("divu lo const", 64'(lo), 64'd3);
    check("divu hi const", 64'(hi), 64'd1);
    idle(1);

    // Both move-to strobes write both registers, then divide by zero
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    exp_hi = 32'h1234; exp_lo = 32'h1234;
    check("mt both", {hi, lo}, {exp_hi, exp_lo});
    run_op(2'd2, 32'd5, 32'd0, 1'b0, "div 5/0");
    idle(1);
    check("dz flag held", 64'(div_by_zero), 64'(exp_dbz));

    // start wins over mtlo in the same cycle (divide by zero leaves lo intact)
    mtlo = 1'b1; wdata = 32'h5555;
    run_op(2'd3, 32'd9, 32'd0, 1'b0, "divu 9/0 mtlo");
    idle(1);

    // Flag clears on the next normal done; ignored start/mthi/mtlo while busy
    run_op(2'd3, 32'd100, 32'd7, 1'b1, "divu 100/7 disturbed");
    check("divu 100/7 lo const", 64'(lo), 64'd14);
    idle(2);

    // Overflowing signed divide
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div ovf");
    check("div ovf lo const", 64'(lo), 64'h8000_0000);
    check("div ovf hi const", 64'(hi), 64'h0);
    idle(1);

    // mtlo while idle
    mtlo = 1'b1; wdata = 32'hAB;
    tick();
    mtlo = 1'b0;
    exp_lo = 32'hAB;
    check("mtlo idle", {hi, lo}, {exp_hi, exp_lo});

    // Reset in the middle of a multiply: no writeback, no done
    start = 1'b1; op = 2'd0; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    tick();
    start = 1'b0;
    repeat (11) tick();
    check("pre-reset busy", 64'(busy), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    check("midop rst hilo", {hi, lo}, 64'(0));
    check("midop rst busy", 64'(busy), 64'(0));
    check("midop rst done", 64'(done), 64'(0));
    seen_done = 1'b0;
    repeat (40) begin
      tick();
      seen_done |= done;
    end
    check("midop no done", 64'(seen_done), 64'(0));

    // Randomized operations with corner operands and random gaps
    for (int n = 0; n < 30; n++) begin
      ra = ($urandom_range(2) == 0) ? corner[$urandom_range(5)] : $urandom;
      rb = ($urandom_range(2) == 0) ? corner[$urandom_range(5)] : $urandom;
      run_op(2'($urandom_range(3)), ra, rb, 1'($urandom_range(1)), "random");
      idle($urandom_range(2));
    end
    idle(1);
    check("final flag", 64'(div_by_zero), 64'(exp_dbz));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
